// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: column drive, row synchronizer, whole-scan debounce, one-cycle key events.
// Define KEYPAD_MULTI_REJECT_EN to treat simultaneous presses as no key (default: lowest index wins).
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]  NoKey  = 4'hF;
  localparam logic [3:0]  DbMax  = 4'(DEBOUNCE_SCANS);

  logic [3:0]        row_s1_q, row_s2_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [1:0]        col_q, col_d;
  logic [2:0][3:0]   snap_q, snap_d;
  logic              scan_done_q, scan_done_d;
  logic [3:0]        last_q, last_d, acc_q, acc_d, cnt_q, cnt_d;
  logic [3:0]        key_code_d;
  logic              key_valid_d, key_held_d;
  logic              last_dwell;
  logic [11:0]       press;
  logic [3:0]        result;

  function automatic logic [3:0] key_of(input int idx);
    logic [3:0] code;
    case (idx)
      9:       code = 4'hA;
      10:      code = 4'h0;
      11:      code = 4'hB;
      default: code = 4'(idx + 1);
    endcase
    return code;
  endfunction

  assign last_dwell = (dwell_q == DwellW'(SCAN_DIV - 1));

  always_comb begin
    unique case (col_q)
      2'd1:    key_col = 3'b101;
      2'd2:    key_col = 3'b011;
      default: key_col = 3'b110;
    endcase
  end

  // Capture at the end of the dwell so the 2-flop sync latency stays inside the column window.
  always_comb begin
    dwell_d     = dwell_q + DwellW'(1);
    col_d       = col_q;
    snap_d      = snap_q;
    scan_done_d = 1'b0;
    if (last_dwell) begin
      dwell_d = '0;
      col_d   = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
      case (col_q)
        2'd1:    snap_d[1] = row_s2_q;
        2'd2:    snap_d[2] = row_s2_q;
        default: snap_d[0] = row_s2_q;
      endcase
      scan_done_d = (col_q == 2'd2);
    end
  end

  always_comb begin
    press = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        press[3*r+c] = ~snap_q[c][r];
      end
    end
    result = NoKey;
    for (int i = 11; i >= 0; i--) begin
      if (press[i]) result = key_of(i);
    end
`ifdef KEYPAD_MULTI_REJECT_EN
    if ($countones(press) > 1) result = NoKey;
`endif
  end

  always_comb begin
    last_d      = last_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    key_code_d  = key_code;
    key_held_d  = key_held;
    key_valid_d = 1'b0;
    if (scan_done_q) begin
      if (result != last_q) begin
        last_d = result;
        cnt_d  = 4'd1;
      end else begin
        cnt_d = (cnt_q >= DbMax) ? DbMax : cnt_q + 4'd1;
      end
      if (cnt_d == DbMax && last_d != acc_q) begin
        acc_d = last_d;
        if (last_d != NoKey) begin
          key_code_d  = last_d;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          key_held_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      dwell_q     <= '0;
      col_q       <= 2'd0;
      snap_q      <= {3{4'hF}};
      scan_done_q <= 1'b0;
      last_q      <= NoKey;
      acc_q       <= NoKey;
      cnt_q       <= 4'd0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      row_s1_q    <= key_row;
      row_s2_q    <= row_s1_q;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      scan_done_q <= scan_done_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      key_code    <= key_code_d;
      key_valid   <= key_valid_d;
      key_held    <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: scan-aligned keypad model plus a scan-level reference model.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int unsigned SD = 4;
  localparam int unsigned DB = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  logic [11:0] pressed = '0;
  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 3; c++) begin
      if (!key_col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[3*r+c]) key_row[r] = 1'b0;
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int pulse_cycle = -1;
  logic [3:0] exp_q[$];
  logic [3:0] exp_code;
  logic [3:0] key_tab [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                               4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

  // Reference state: run of identical scan results and the accepted key.
  logic [3:0] m_run, m_acc, m_code;
  int         m_len;
  logic       m_held;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every key_valid pulse must match the head of the expected-event queue.
  always @(negedge clk) begin
    if (reset_n && key_valid) begin
      tests++;
      pulse_cycle = cycle;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got key_code %0h, expected no event", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code || key_held !== 1'b1) begin
          fails++;
          $display("FAIL pulse: got code %0h held %0b, expected code %0h held 1",
                   key_code, key_held, exp_code);
        end
      end
    end
  end

  function automatic logic [3:0] scan_result(input logic [11:0] p);
    if (p == 0) return 4'hF;
`ifdef KEYPAD_MULTI_REJECT_EN
    if ($countones(p) > 1) return 4'hF;
`endif
    for (int i = 0; i < 12; i++) begin
      if (p[i]) return key_tab[i];
    end
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_run = 4'hF; m_acc = 4'hF; m_code = 4'h0; m_len = 0; m_held = 1'b0;
  endtask

  task automatic model_scan(input logic [3:0] r);
    if (r == m_run) m_len = (m_len >= DB) ? DB : m_len + 1;
    else begin
      m_run = r;
      m_len = 1;
    end
    if (m_len >= DB && m_run != m_acc) begin
      m_acc = m_run;
      if (m_run != 4'hF) begin
        m_code = m_run;
        m_held = 1'b1;
        exp_q.push_back(m_run);
      end else begin
        m_held = 1'b0;
      end
    end
  endtask

  // Called #1 after a scan-boundary edge; holds pattern p for one full scan.
  task automatic run_scan(input logic [11:0] p);
    logic [2:0] ec;
    pressed = p;
    for (int j = 0; j < 3 * SD; j++) begin
      ec = 3'b111;
      ec[j / SD] = 1'b0;
      check("key_col", 32'(key_col), 32'(ec));
      if (j == 6) begin
        check("key_held", 32'(key_held), 32'(m_held));
        check("key_code", 32'(key_code), 32'(m_code));
      end
      @(posedge clk);
      #1;
    end
    model_scan(scan_result(p));
  endtask

  task automatic do_reset(output int rel_cycle);
    reset_n = 1'b0;
    #1;
    check("rst_key_col", 32'(key_col), 32'(3'b110));
    check("rst_key_code", 32'(key_code), 0);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_held", 32'(key_held), 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rel_cycle = cycle;
  endtask

  initial begin
    int rel, t0, hold, kind;
    logic [11:0] p;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset(rel);

    // Idle: columns rotate, no events.
    repeat (3) run_scan('0);

    // Clean press/release of key 5 with latency bound.
    pulse_cycle = -1;
    t0 = cycle;
    repeat (4) run_scan(12'h1 << 4);
    check("press_latency_ok", int'(pulse_cycle >= t0 + int'(DB * 3 * SD) &&
                                   pulse_cycle <= t0 + int'((DB + 1) * 3 * SD + 3)), 1);
    repeat (3) run_scan('0);

    // Bounce on key 9: one scan pressed, one released.
    repeat (3) begin
      run_scan(12'h1 << 8);
      run_scan('0);
    end

    // Row 3: *, 0, #.
    for (int k = 9; k < 12; k++) begin
      repeat (5) run_scan(12'h1 << k);
      repeat (3) run_scan('0);
    end

    // Keys 1 and 5 together.
    repeat (5) run_scan(12'h011);
    repeat (3) run_scan('0);

    // Random segments, including direct key-to-key transitions.
    for (int s = 0; s < 40; s++) begin
      kind = int'($urandom_range(0, 3));
      p = '0;
      if (kind == 1 || kind == 2) p[$urandom_range(0, 11)] = 1'b1;
      else if (kind == 3) begin
        p[$urandom_range(0, 11)] = 1'b1;
        p[$urandom_range(0, 11)] = 1'b1;
      end
      hold = int'($urandom_range(1, 3));
      repeat (hold) run_scan(p);
    end
    repeat (3) run_scan('0);

    // Reset mid-debounce with key 3 held through reset.
    run_scan(12'h1 << 2);
    repeat (5) @(posedge clk);
    #1;
    do_reset(rel);
    pulse_cycle = -1;
    repeat (4) run_scan(12'h1 << 2);
    check("post_reset_pulse_window", int'(pulse_cycle >= rel + int'(2 * 3 * SD) &&
                                          pulse_cycle <= rel + int'(3 * 3 * SD)), 1);
    repeat (3) run_scan('0);

    check("events_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
